factor_quiz_ctrl: RTL and testbench
===================================

Name: factor_quiz_ctrl

Overview:
Game sequencer for the factorization quiz board. It drives the STATE, QUE and DIN buses consumed by the seven-segment decoder and walks through a fixed question list. For each question it shows the number, accepts the player's answer selection, judges it and keeps the score. Button inputs are debounced levels from the board; this block synchronizes them and detects edges.

Parameters:
TICK_DIV, 50_000_000, CLK cycles per display tick (1 s at 50 MHz)
SHOW_TICKS, 3, ticks spent in READY, QUESTION and RESULT each
NUM_Q, 4, number of questions per game (1..8)

Ports:
CLK  in  1  system clock, all logic on the rising edge
nRST  in  1  one clock; reset is synchronous and active-low
BTN_START  in  1  start/restart button, debounced level, active-high
BTN_NEXT  in  1  advance answer selection, debounced level
BTN_ENTER  in  1  submit answer, debounced level
STATE  out  4  game state code to the decoder
QUE  out  4  question digit 0..9
DIN  out  4  answer selection index 0..9 (0 = none)
SCORE  out  4  correct answers this game, saturating at 15
CORRECT  out  1  one-cycle pulse on a correct judgement

Behaviour:
- Reset (nRST low at a CLK edge): STATE=4'b0001 (IDLE), QUE=0, DIN=0, SCORE=0, CORRECT=0, question index q=0, tick counter=0. Reset applies from any state, including mid-question.
- Buttons: 2-flop synchronizer, then rising-edge detect. A level rising before edge k produces a pulse that acts at edge k+2, so STATE changes on the 3rd edge after the press. Holding a button gives one pulse only.
- Timer: cycle counter 0..TICK_DIV-1 emits a tick on wrap; tick count 0..SHOW_TICKS. Both clear on every STATE change, so a timed state lasts exactly SHOW_TICKS*TICK_DIV cycles.
- State codes: IDLE 0001, READY 0010, QUESTION 0011, INPUT 0100, JUDGE 0101, RESULT 0110, DONE 0111. Any other code falls back to IDLE on the next edge.
- IDLE: on START pulse -> READY; SCORE=0, q=0.
- READY: after SHOW_TICKS -> QUESTION; QUE loads ROM_Q[q].
- QUESTION: after SHOW_TICKS -> INPUT; DIN cleared to 0.
- INPUT, NEXT pulse: DIN = (DIN==9) ? 1 : DIN+1. From 0 it goes to 1.
- INPUT, ENTER pulse with DIN!=0 -> JUDGE. ENTER with DIN==0 is ignored.
- INPUT, NEXT and ENTER in the same cycle: ENTER wins and DIN is not incremented.
- INPUT has no timeout.
- JUDGE (exactly 1 cycle): if DIN==ROM_A[q], SCORE=min(SCORE+1,15) and CORRECT=1 for that edge's output cycle. Then -> RESULT.
- RESULT: after SHOW_TICKS, if q==NUM_Q-1 -> DONE, else q=q+1, QUE loads ROM_Q[q+1] and -> QUESTION.
- DONE: SCORE held; START pulse -> READY (SCORE=0, q=0).
- Pulses of START, NEXT or ENTER in states that do not use them are discarded, not queued.
- QUE and DIN hold their values outside the states that update them.
- All outputs are registered.

Decomposition:
- Package factor_quiz_pkg holds:
  - the 4-bit state code localparams;
  - NUM_Q_MAX=8;
  - question ROM constants ROM_Q = {9,4,7,5,6,8,3,2} and answer ROM ROM_A = {2,1,4,3,1,1,2,1} (DIN index of the expected prime).
- One sub-module, btn_edge: 2-flop synchronizer plus rising-edge one-shot, with CLK and nRST. It is instantiated three times.

Test Plan:
(sim TICK_DIV=4, SHOW_TICKS=2, NUM_Q=4)
1. Reset, then START high -> STATE 0001 to 0010 on the 3rd edge. STATE goes to 0011 8 cycles later with QUE=9, and to 0100 8 cycles after that with DIN=0.
2. In INPUT, NEXT x2, then ENTER -> DIN=2, JUDGE lasts 1 cycle, CORRECT pulses once, SCORE=1, RESULT lasts 8 cycles, then QUESTION with QUE=4.
3. In INPUT, ENTER with DIN=0 -> stays 0100. NEXT x10 -> DIN=1 after wrap (sequence 1..9,1). NEXT+ENTER same cycle at DIN=1 -> judged with DIN=1, no increment.
4. Full game answering 2,1,1(wrong),3 -> DONE 0111 with SCORE=3. Then START -> 0010 with SCORE=0 and q=0.
5. nRST low for 1 cycle during INPUT with DIN=5 -> next edge STATE=0001, QUE=0, DIN=0, SCORE=0, CORRECT=0.
6. Button held high for 20 cycles in INPUT (NEXT) -> DIN increments exactly once. START pressed in INPUT -> no state change.

Source files
------------

// File: rtl/factor_quiz_pkg.sv
// ---------------------------------------------------------------------------
// factor_quiz_pkg
// Shared constants for the factorization quiz sequencer: the 4-bit state
// codes seen by the seven-segment decoder, the state enum built on them,
// and the question / answer ROMs.
// ---------------------------------------------------------------------------
package factor_quiz_pkg;

   // State codes driven onto the STATE bus.
   localparam logic [3:0] ST_IDLE     = 4'b0001;
   localparam logic [3:0] ST_READY    = 4'b0010;
   localparam logic [3:0] ST_QUESTION = 4'b0011;
   localparam logic [3:0] ST_INPUT    = 4'b0100;
   localparam logic [3:0] ST_JUDGE    = 4'b0101;
   localparam logic [3:0] ST_RESULT   = 4'b0110;
   localparam logic [3:0] ST_DONE     = 4'b0111;

   typedef enum logic [3:0] {
      S_IDLE     = ST_IDLE,
      S_READY    = ST_READY,
      S_QUESTION = ST_QUESTION,
      S_INPUT    = ST_INPUT,
      S_JUDGE    = ST_JUDGE,
      S_RESULT   = ST_RESULT,
      S_DONE     = ST_DONE
   } state_t;

   localparam int NUM_Q_MAX = 8;

   // Question digit shown for each question index.
   localparam logic [3:0] ROM_Q [NUM_Q_MAX] =
      '{4'd9, 4'd4, 4'd7, 4'd5, 4'd6, 4'd8, 4'd3, 4'd2};

   // DIN selection index that names the expected prime for each question.
   localparam logic [3:0] ROM_A [NUM_Q_MAX] =
      '{4'd2, 4'd1, 4'd4, 4'd3, 4'd1, 4'd1, 4'd2, 4'd1};

endpackage

// File: rtl/factor_quiz_ctrl_btn_edge.sv
// ---------------------------------------------------------------------------
// btn_edge
// Brings one debounced button level into the CLK domain through a 2-flop
// synchronizer and turns its rising edge into a single-cycle pulse.
// A level that rises before edge k yields a pulse that is acted upon at
// edge k+2. Holding the button produces only one pulse.
//
// Ports:
//   CLK    in   system clock
//   nRST   in   synchronous active-low reset
//   level  in   debounced button level, active-high
//   pulse  out  one-cycle pulse on a synchronized rising edge
// ---------------------------------------------------------------------------
module btn_edge (
   input  logic CLK,
   input  logic nRST,
   input  logic level,
   output logic pulse
);

   logic sync1;
   logic sync2;
   logic prev;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour; blocking here would
   // collapse the synchronizer chain into a single stage.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= level;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   // Decoded from flops only, so the pulse is clean for one full cycle.
   assign pulse = sync2 & ~prev;

endmodule

// File: rtl/factor_quiz_ctrl.sv
// ---------------------------------------------------------------------------
// factor_quiz_ctrl
// Game sequencer for the factorization quiz board. Walks the question ROM,
// shows each number for a fixed time, lets the player step through answer
// indices, judges the selection and keeps a saturating score.
//
// Parameters:
//   TICK_DIV    CLK cycles per display tick
//   SHOW_TICKS  ticks spent in READY, QUESTION and RESULT
//   NUM_Q       questions per game (1..8)
//
// Ports:
//   CLK        in   system clock
//   nRST       in   synchronous active-low reset
//   BTN_START  in   start/restart button level
//   BTN_NEXT   in   advance answer selection level
//   BTN_ENTER  in   submit answer level
//   STATE      out  game state code to the decoder
//   QUE        out  question digit
//   DIN        out  answer selection index (0 = none)
//   SCORE      out  correct answers this game, saturating at 15
//   CORRECT    out  one-cycle pulse on a correct judgement
// ---------------------------------------------------------------------------
module factor_quiz_ctrl
   import factor_quiz_pkg::*;
#(
   parameter int TICK_DIV   = 50_000_000,
   parameter int SHOW_TICKS = 3,
   parameter int NUM_Q      = 4
) (
   input  logic       CLK,
   input  logic       nRST,
   input  logic       BTN_START,
   input  logic       BTN_NEXT,
   input  logic       BTN_ENTER,
   output logic [3:0] STATE,
   output logic [3:0] QUE,
   output logic [3:0] DIN,
   output logic [3:0] SCORE,
   output logic       CORRECT
);

   localparam int CYC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int TICK_W = (SHOW_TICKS > 0) ? $clog2(SHOW_TICKS + 1) : 1;

   localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(TICK_DIV - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SHOW_TICKS - 1);
   localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(SHOW_TICKS);
   localparam logic [2:0]        Q_LAST    = 3'(NUM_Q - 1);

   logic start_p;
   logic next_p;
   logic enter_p;

   btn_edge u_start (.CLK(CLK), .nRST(nRST), .level(BTN_START), .pulse(start_p));
   btn_edge u_next  (.CLK(CLK), .nRST(nRST), .level(BTN_NEXT),  .pulse(next_p));
   btn_edge u_enter (.CLK(CLK), .nRST(nRST), .level(BTN_ENTER), .pulse(enter_p));

   state_t            state;
   logic [CYC_W-1:0]  cyc;
   logic [TICK_W-1:0] tcnt;
   logic [2:0]        q;

   // True on the last cycle of a timed state: the edge that would complete
   // tick number SHOW_TICKS. Timed states therefore last SHOW_TICKS*TICK_DIV.
   logic show_done;
   assign show_done = (cyc == CYC_LAST) && (tcnt == TICK_LAST);

   assign STATE = state;

   // NOTE: the question/answer ROMs are constants, so they need no reset;
   // only the real state registers below are cleared.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state   <= S_IDLE;
         QUE     <= 4'd0;
         DIN     <= 4'd0;
         SCORE   <= 4'd0;
         CORRECT <= 1'b0;
         q       <= 3'd0;
         cyc     <= '0;
         tcnt    <= '0;
      end else begin
         CORRECT <= 1'b0;

         // Free-running display timer; any state change below overrides
         // these updates and restarts it from zero.
         if (cyc == CYC_LAST) begin
            cyc <= '0;
            if (tcnt != TICK_MAX) tcnt <= tcnt + 1'b1;
         end else begin
            cyc <= cyc + 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (start_p) begin
                  state <= S_READY;
                  SCORE <= 4'd0;
                  q     <= 3'd0;
                  cyc   <= '0;
                  tcnt  <= '0;
               end
            end

            S_READY: begin
               if (show_done) begin
                  state <= S_QUESTION;
                  QUE   <= ROM_Q[q];
                  cyc   <= '0;
                  tcnt  <= '0;
               end
            end

            S_QUESTION: begin
               if (show_done) begin
                  state <= S_INPUT;
                  DIN   <= 4'd0;
                  cyc   <= '0;
                  tcnt  <= '0;
               end
            end

            S_INPUT: begin
               // ENTER takes priority and always suppresses a coincident NEXT.
               if (enter_p) begin
                  if (DIN != 4'd0) begin
                     state <= S_JUDGE;
                     cyc   <= '0;
                     tcnt  <= '0;
                  end
               end else if (next_p) begin
                  DIN <= (DIN == 4'd9) ? 4'd1 : DIN + 4'd1;
               end
            end

            S_JUDGE: begin
               if (DIN == ROM_A[q]) begin
                  CORRECT <= 1'b1;
                  if (SCORE != 4'd15) SCORE <= SCORE + 4'd1;
               end
               state <= S_RESULT;
               cyc   <= '0;
               tcnt  <= '0;
            end

            S_RESULT: begin
               if (show_done) begin
                  if (q == Q_LAST) begin
                     state <= S_DONE;
                  end else begin
                     q     <= q + 3'd1;
                     QUE   <= ROM_Q[3'(q + 3'd1)];
                     state <= S_QUESTION;
                  end
                  cyc  <= '0;
                  tcnt <= '0;
               end
            end

            S_DONE: begin
               if (start_p) begin
                  state <= S_READY;
                  SCORE <= 4'd0;
                  q     <= 3'd0;
                  cyc   <= '0;
                  tcnt  <= '0;
               end
            end

            default: begin
               state <= S_IDLE;
               cyc   <= '0;
               tcnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_factor_quiz_ctrl.sv
// ---------------------------------------------------------------------------
// tb_factor_quiz_ctrl
// Directed bench for the quiz sequencer with TICK_DIV=4, SHOW_TICKS=2,
// NUM_Q=4, so every timed state lasts 8 cycles.
// ---------------------------------------------------------------------------
module tb_factor_quiz_ctrl;

   localparam logic [3:0] C_IDLE     = 4'b0001;
   localparam logic [3:0] C_READY    = 4'b0010;
   localparam logic [3:0] C_QUESTION = 4'b0011;
   localparam logic [3:0] C_INPUT    = 4'b0100;
   localparam logic [3:0] C_JUDGE    = 4'b0101;
   localparam logic [3:0] C_RESULT   = 4'b0110;
   localparam logic [3:0] C_DONE     = 4'b0111;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn_start;
   logic       btn_next;
   logic       btn_enter;
   logic [3:0] state;
   logic [3:0] que;
   logic [3:0] din;
   logic [3:0] score;
   logic       correct;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   factor_quiz_ctrl #(
      .TICK_DIV  (4),
      .SHOW_TICKS(2),
      .NUM_Q     (4)
   ) dut (
      .CLK      (clk),
      .nRST     (rst_n),
      .BTN_START(btn_start),
      .BTN_NEXT (btn_next),
      .BTN_ENTER(btn_enter),
      .STATE    (state),
      .QUE      (que),
      .DIN      (din),
      .SCORE    (score),
      .CORRECT  (correct)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance n rising edges; outputs are then sampled 1 time unit later.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One-cycle press; the synchronized pulse has acted when this returns.
   task automatic press_next();
      btn_next = 1'b1; step(1); btn_next = 1'b0; step(2);
   endtask

   task automatic press_enter();
      btn_enter = 1'b1; step(1); btn_enter = 1'b0; step(2);
   endtask

   task automatic press_start();
      btn_start = 1'b1; step(1); btn_start = 1'b0; step(2);
   endtask

   // Bounded wait for a state code; an expired budget shows up as a failed check.
   task automatic wait_state(input string tag, input logic [3:0] code, input int budget);
      int n = 0;
      while (state !== code && n < budget) begin
         step(1);
         n++;
      end
      check(tag, {12'd0, state}, {12'd0, code});
   endtask

   initial begin
      rst_n     = 1'b0;
      btn_start = 1'b0;
      btn_next  = 1'b0;
      btn_enter = 1'b0;
      step(2);

      // 1. Reset state and start-up timing
      check("rst_state",   {12'd0, state}, {12'd0, C_IDLE});
      check("rst_que",     {12'd0, que},   16'd0);
      check("rst_din",     {12'd0, din},   16'd0);
      check("rst_score",   {12'd0, score}, 16'd0);
      check("rst_correct", {15'd0, correct}, 16'd0);

      rst_n     = 1'b1;
      btn_start = 1'b1;
      step(1);
      btn_start = 1'b0;
      step(1);
      check("start_edge2", {12'd0, state}, {12'd0, C_IDLE});
      step(1);
      check("start_edge3", {12'd0, state}, {12'd0, C_READY});
      step(7);
      check("ready_len7",  {12'd0, state}, {12'd0, C_READY});
      step(1);
      check("ready_to_q",  {12'd0, state}, {12'd0, C_QUESTION});
      check("que_q0",      {12'd0, que},   16'd9);
      step(7);
      check("q_len7",      {12'd0, state}, {12'd0, C_QUESTION});
      step(1);
      check("q_to_input",  {12'd0, state}, {12'd0, C_INPUT});
      check("din_cleared", {12'd0, din},   16'd0);

      // 2. Answer 2 to question 9 (correct)
      press_next();
      check("din_next1",   {12'd0, din},   16'd1);
      press_next();
      check("din_next2",   {12'd0, din},   16'd2);
      press_enter();
      check("judge_state", {12'd0, state}, {12'd0, C_JUDGE});
      check("judge_nocor", {15'd0, correct}, 16'd0);
      step(1);
      check("result_state",{12'd0, state}, {12'd0, C_RESULT});
      check("cor_pulse",   {15'd0, correct}, 16'd1);
      check("score1",      {12'd0, score}, 16'd1);
      step(1);
      check("cor_one_cyc", {15'd0, correct}, 16'd0);
      step(6);
      check("result_len7", {12'd0, state}, {12'd0, C_RESULT});
      step(1);
      check("result_to_q", {12'd0, state}, {12'd0, C_QUESTION});
      check("que_q1",      {12'd0, que},   16'd4);

      // 3. ENTER with no selection, NEXT wrap, NEXT+ENTER together
      step(8);
      check("q1_input",    {12'd0, state}, {12'd0, C_INPUT});
      press_enter();
      check("enter_din0",  {12'd0, state}, {12'd0, C_INPUT});
      for (int i = 1; i <= 10; i++) begin
         press_next();
         check($sformatf("din_seq%0d", i), {12'd0, din}, (i <= 9) ? 16'(i) : 16'd1);
      end
      btn_next  = 1'b1;
      btn_enter = 1'b1;
      step(1);
      btn_next  = 1'b0;
      btn_enter = 1'b0;
      step(2);
      check("both_judge",  {12'd0, state}, {12'd0, C_JUDGE});
      check("both_noinc",  {12'd0, din},   16'd1);
      step(1);
      check("q1_correct",  {15'd0, correct}, 16'd1);
      check("score2",      {12'd0, score}, 16'd2);

      // 4. Rest of game: wrong answer on 7, correct 3 on 5
      wait_state("to_q2", C_QUESTION, 20);
      check("que_q2",      {12'd0, que},   16'd7);
      wait_state("q2_input", C_INPUT, 20);
      press_next();
      press_enter();
      step(1);
      check("q2_wrong",    {15'd0, correct}, 16'd0);
      check("score_hold2", {12'd0, score}, 16'd2);
      wait_state("to_q3", C_QUESTION, 20);
      check("que_q3",      {12'd0, que},   16'd5);
      wait_state("q3_input", C_INPUT, 20);
      press_next();
      press_next();
      press_next();
      press_enter();
      step(1);
      check("q3_correct",  {15'd0, correct}, 16'd1);
      wait_state("to_done", C_DONE, 20);
      check("done_score",  {12'd0, score}, 16'd3);
      step(5);
      check("done_hold",   {12'd0, state}, {12'd0, C_DONE});
      press_start();
      check("restart",     {12'd0, state}, {12'd0, C_READY});
      check("restart_scr", {12'd0, score}, 16'd0);
      wait_state("restart_q", C_QUESTION, 20);
      check("restart_q0",  {12'd0, que},   16'd9);

      // 5. Reset in the middle of INPUT
      wait_state("rst_input", C_INPUT, 20);
      for (int i = 0; i < 5; i++) press_next();
      check("din5",        {12'd0, din},   16'd5);
      rst_n = 1'b0;
      step(1);
      check("mid_rst_st",  {12'd0, state}, {12'd0, C_IDLE});
      check("mid_rst_que", {12'd0, que},   16'd0);
      check("mid_rst_din", {12'd0, din},   16'd0);
      check("mid_rst_scr", {12'd0, score}, 16'd0);
      check("mid_rst_cor", {15'd0, correct}, 16'd0);
      rst_n = 1'b1;

      // 6. Held button gives one pulse; START ignored in INPUT
      press_start();
      check("re_ready",    {12'd0, state}, {12'd0, C_READY});
      wait_state("hold_input", C_INPUT, 40);
      btn_next = 1'b1;
      step(20);
      btn_next = 1'b0;
      step(2);
      check("hold_once",   {12'd0, din},   16'd1);
      press_start();
      check("start_ign",   {12'd0, state}, {12'd0, C_INPUT});
      step(10);
      check("start_ign2",  {12'd0, state}, {12'd0, C_INPUT});
      check("start_din",   {12'd0, din},   16'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
